// File: rtl/acq_scheduler_pkg.sv
// Shared types and constants for the acquisition scheduler: FSM states,
// trigger-timestamp field layout and RTC millisecond range.
package acq_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        RUN,
        REPORT
    } state_t;

    localparam int MS_PER_SEC = 1000;
    localparam int MS_W       = $clog2(MS_PER_SEC);
    localparam int TS_W       = 32;

    localparam int MS_LSB   = 0;
    localparam int SEC_LSB  = 10;
    localparam int MIN_LSB  = 16;
    localparam int HOUR_LSB = 22;
    localparam int DAY_LSB  = 27;

    function automatic logic [TS_W-1:0] pack_ts(
        input logic [4:0]      day,
        input logic [4:0]      hour,
        input logic [5:0]      min,
        input logic [5:0]      sec,
        input logic [MS_W-1:0] ms
    );
        logic [TS_W-1:0] ts;
        ts                 = '0;
        ts[DAY_LSB  +: 5]  = day;
        ts[HOUR_LSB +: 5]  = hour;
        ts[MIN_LSB  +: 6]  = min;
        ts[SEC_LSB  +: 6]  = sec;
        ts[MS_LSB   +: MS_W] = ms;
        return ts;
    endfunction

endpackage

// File: rtl/acq_scheduler_rtc_tick_detect.sv
// Detects millisecond ticks and second boundaries on the free-running RTC
// millisecond field by comparing it with its value from the previous cycle.
module rtc_tick_detect
    import acq_scheduler_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic [MS_W-1:0] rtc_millisec,
    output logic            ms_tick,
    output logic            sec_tick
);

    logic [MS_W-1:0] prev_ms;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_ms <= '0;
        end else begin
            prev_ms <= rtc_millisec;
        end
    end

    // Ticks are combinational so the FSM can act in the very cycle the RTC changes.
    assign ms_tick  = (rtc_millisec != prev_ms);
    assign sec_tick = ms_tick && (rtc_millisec == '0);

endmodule

// File: rtl/acq_scheduler.sv
// Schedules periodic spectrogram captures on RTC second boundaries, bounds each
// capture by a millisecond window and hands the trigger timestamp to readout.
module acq_scheduler
    import acq_scheduler_pkg::*;
#(
    parameter int PERIOD_W = 8,
    parameter int WIN_W    = 10,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period_sec,
    input  logic [WIN_W-1:0]    window_ms,
    input  logic [9:0]          rtc_millisec,
    input  logic [5:0]          rtc_sec,
    input  logic [5:0]          rtc_min,
    input  logic [4:0]          rtc_hour,
    input  logic [4:0]          rtc_day,
    output logic                ext_start,
    input  logic                ext_busy,
    input  logic                ext_done,
    output logic                ext_abort,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [31:0]         ts_data,
    output logic                ts_aborted,
    output logic [CNT_W-1:0]    frame_count,
    output logic                overrun,
    input  logic                clear_overrun
);

    logic ms_tick;
    logic sec_tick;

    rtc_tick_detect u_tick (
        .clk          (clk),
        .reset_n      (reset_n),
        .rtc_millisec (rtc_millisec),
        .ms_tick      (ms_tick),
        .sec_tick     (sec_tick)
    );

    state_t              state;
    logic [PERIOD_W-1:0] period_cnt;
    logic [WIN_W-1:0]    win_cnt;

    logic [PERIOD_W:0]   period_eff;
    logic [PERIOD_W:0]   period_next;
    logic [WIN_W:0]      win_eff;
    logic [WIN_W:0]      win_next;
    logic                trigger;
    logic                drop;
    logic                timeout;

    // NOTE: every signal here is assigned on every path, so no latch is inferred.
    always_comb begin
        period_eff  = (period_sec == '0) ? {{PERIOD_W{1'b0}}, 1'b1} : {1'b0, period_sec};
        win_eff     = (window_ms == '0)  ? {{WIN_W{1'b0}}, 1'b1}    : {1'b0, window_ms};
        period_next = {1'b0, period_cnt} + {{PERIOD_W{1'b0}}, 1'b1};
        win_next    = {1'b0, win_cnt} + {{WIN_W{1'b0}}, 1'b1};
        // >= rather than == so a period shortened below the running count fires at once.
        trigger     = sec_tick && enable && (state != IDLE) && (period_next >= period_eff);
        drop        = trigger && ((state != ARMED) || ext_busy);
        timeout     = ms_tick && (win_next >= win_eff);
    end

    // Free-running period counter: restarts on every trigger, taken or dropped,
    // so the capture cadence never depends on how long a frame takes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
        end else if (state == IDLE) begin
            period_cnt <= '0;
        end else if (sec_tick && enable) begin
            period_cnt <= trigger ? '0 : period_next[PERIOD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= drop || (overrun && !clear_overrun);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            win_cnt     <= '0;
            ext_start   <= 1'b0;
            ext_abort   <= 1'b0;
            ts_valid    <= 1'b0;
            ts_data     <= '0;
            ts_aborted  <= 1'b0;
            frame_count <= '0;
        end else begin
            ext_start <= 1'b0;
            ext_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (trigger && !ext_busy) begin
                        state     <= START;
                        ext_start <= 1'b1;
                        ts_data   <= pack_ts(rtc_day, rtc_hour, rtc_min, rtc_sec, rtc_millisec);
                    end else if (!enable) begin
                        state <= IDLE;
                    end
                end
                START: begin
                    win_cnt <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    // A completion arriving together with the timeout tick wins.
                    if (ext_done) begin
                        state      <= REPORT;
                        ts_valid   <= 1'b1;
                        ts_aborted <= 1'b0;
                    end else if (timeout) begin
                        state      <= REPORT;
                        ext_abort  <= 1'b1;
                        ts_valid   <= 1'b1;
                        ts_aborted <= 1'b1;
                    end else if (ms_tick) begin
                        win_cnt <= win_next[WIN_W-1:0];
                    end
                end
                REPORT: begin
                    if (ts_valid && ts_ready) begin
                        ts_valid    <= 1'b0;
                        frame_count <= frame_count + CNT_W'(1);
                        state       <= enable ? ARMED : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acq_scheduler.sv
// Directed bench for acq_scheduler: a table of capture scenarios plus
// hand-written sequences for back-pressure, busy drops and mid-capture reset.
module tb_acq_scheduler;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [7:0]  period_sec;
    logic [9:0]  window_ms;
    logic [9:0]  r_ms;
    logic [5:0]  r_sec;
    logic [5:0]  r_min;
    logic [4:0]  r_hour;
    logic [4:0]  r_day;
    logic        ext_start;
    logic        ext_busy;
    logic        ext_done;
    logic        ext_abort;
    logic        ts_valid;
    logic        ts_ready;
    logic [31:0] ts_data;
    logic        ts_aborted;
    logic [15:0] frame_count;
    logic        overrun;
    logic        clear_overrun;

    acq_scheduler #(.PERIOD_W(8), .WIN_W(10), .CNT_W(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .period_sec    (period_sec),
        .window_ms     (window_ms),
        .rtc_millisec  (r_ms),
        .rtc_sec       (r_sec),
        .rtc_min       (r_min),
        .rtc_hour      (r_hour),
        .rtc_day       (r_day),
        .ext_start     (ext_start),
        .ext_busy      (ext_busy),
        .ext_done      (ext_done),
        .ext_abort     (ext_abort),
        .ts_valid      (ts_valid),
        .ts_ready      (ts_ready),
        .ts_data       (ts_data),
        .ts_aborted    (ts_aborted),
        .frame_count   (frame_count),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int period;
        int window;
        int done_after;
        int seconds;
        int starts;
        int aborts;
        int abort_ms;
        int frames;
        int first_sec;
        int step_sec;
        bit aborted;
    } vec_t;

    vec_t rows[5];

    int checks = 0;
    int errors = 0;

    int start_cnt, abort_cnt, bad_lat, bad_abort;
    int cyc_since_ms, ms_since, done_after, cur_abort_ms;
    bit ext_running, auto_ready, clr_on_boundary;
    int start_sec_q[$];
    logic [31:0] log_data[$];
    bit log_ab[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expect_ts(input int sec);
        return {5'd3, 5'd7, 6'd12, 6'(sec), 10'd0};
    endfunction

    // One clock; samples outputs 1 time unit after the edge and models the consumer.
    task automatic step();
        @(posedge clk);
        #1;
        cyc_since_ms++;
        if (ext_start) begin
            start_cnt++;
            start_sec_q.push_back(int'(r_sec));
            if (cyc_since_ms != 1 || r_ms != 10'd0) bad_lat++;
            ext_running = 1'b1;
            ms_since    = 0;
        end
        if (ext_abort) begin
            abort_cnt++;
            if (int'(r_ms) != cur_abort_ms) bad_abort++;
            ext_running = 1'b0;
        end
        ts_ready = auto_ready;
        if (ts_valid && ts_ready) begin
            log_data.push_back(ts_data);
            log_ab.push_back(ts_aborted);
        end
    endtask

    // Advances the RTC by one millisecond, held for two clocks; models ext_done.
    task automatic ms_step();
        if (r_ms == 10'(acq_scheduler_pkg::MS_PER_SEC - 1)) begin
            r_ms  = 10'd0;
            r_sec = (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
        end else begin
            r_ms = r_ms + 10'd1;
        end
        cyc_since_ms = 0;
        if (ext_running) begin
            ms_since++;
            if (done_after != 0 && ms_since == done_after) begin
                ext_done    = 1'b1;
                ext_running = 1'b0;
            end
        end
        if (r_ms == 10'd0 && clr_on_boundary) clear_overrun = 1'b1;
        step();
        ext_done      = 1'b0;
        clear_overrun = 1'b0;
        step();
    endtask

    // Ten ms of activity, then a jump to the end of the second and the boundary.
    task automatic next_second();
        repeat (10) ms_step();
        r_ms = 10'(acq_scheduler_pkg::MS_PER_SEC - 2);
        ms_step();
        ms_step();
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        enable          = 1'b0;
        ext_busy        = 1'b0;
        ext_done        = 1'b0;
        clear_overrun   = 1'b0;
        clr_on_boundary = 1'b0;
        auto_ready      = 1'b1;
        r_ms            = 10'd0;
        r_sec           = 6'd0;
        ext_running     = 1'b0;
        ms_since        = 0;
        step();
        step();
        start_cnt = 0;
        abort_cnt = 0;
        bad_lat   = 0;
        bad_abort = 0;
        start_sec_q.delete();
        log_data.delete();
        log_ab.delete();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // period, window, done_after, seconds, starts, aborts, abort_ms, frames, first_sec, step_sec, aborted
        rows[0] = '{2, 5, 3, 6, 3, 0, 0, 3, 2, 2, 1'b0};
        rows[1] = '{1, 4, 0, 3, 3, 3, 4, 3, 1, 1, 1'b1};
        rows[2] = '{1, 4, 4, 2, 2, 0, 0, 2, 1, 1, 1'b0};
        rows[3] = '{0, 0, 0, 2, 2, 2, 1, 2, 1, 1, 1'b1};
        rows[4] = '{3, 5, 2, 7, 2, 0, 0, 2, 3, 3, 1'b0};

        r_day = 5'd3; r_hour = 5'd7; r_min = 6'd12;
        r_ms = 10'd0; r_sec = 6'd0;
        period_sec = 8'd1; window_ms = 10'd5;
        enable = 1'b0; ext_busy = 1'b0; ext_done = 1'b0;
        ts_ready = 1'b0; clear_overrun = 1'b0; auto_ready = 1'b0;
        clr_on_boundary = 1'b0; ext_running = 1'b0; done_after = 0; cur_abort_ms = 0;
        start_cnt = 0; abort_cnt = 0; bad_lat = 0; bad_abort = 0;
        cyc_since_ms = 0; ms_since = 0;

        reset_n = 1'b0;
        step();
        check("reset ext_start", ext_start, 0);
        check("reset ext_abort", ext_abort, 0);
        check("reset ts_valid", ts_valid, 0);
        check("reset ts_data", ts_data, 0);
        check("reset ts_aborted", ts_aborted, 0);
        check("reset frame_count", frame_count, 0);
        check("reset overrun", overrun, 0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            period_sec   = 8'(rows[i].period);
            window_ms    = 10'(rows[i].window);
            done_after   = rows[i].done_after;
            cur_abort_ms = rows[i].abort_ms;
            enable       = 1'b1;
            repeat (rows[i].seconds) next_second();
            repeat (10) ms_step();
            check($sformatf("row%0d starts", i), start_cnt, rows[i].starts);
            check($sformatf("row%0d aborts", i), abort_cnt, rows[i].aborts);
            check($sformatf("row%0d frame_count", i), frame_count, rows[i].frames);
            check($sformatf("row%0d overrun", i), overrun, 0);
            check($sformatf("row%0d start latency", i), bad_lat, 0);
            check($sformatf("row%0d abort tick", i), bad_abort, 0);
            check($sformatf("row%0d handshakes", i), log_data.size(), rows[i].frames);
            for (int k = 0; k < start_sec_q.size(); k++)
                check($sformatf("row%0d start%0d sec", i, k), start_sec_q[k],
                      rows[i].first_sec + k * rows[i].step_sec);
            for (int k = 0; k < log_data.size(); k++) begin
                check($sformatf("row%0d ts%0d data", i, k), log_data[k],
                      expect_ts(rows[i].first_sec + k * rows[i].step_sec));
                check($sformatf("row%0d ts%0d aborted", i, k), log_ab[k], rows[i].aborted);
            end
        end

        // Consumer stalls for three seconds: timestamp held, later triggers dropped.
        do_reset();
        period_sec = 8'd1; window_ms = 10'd5; done_after = 3; cur_abort_ms = 5;
        auto_ready = 1'b0; enable = 1'b1;
        next_second();
        repeat (10) ms_step();
        repeat (3) next_second();
        check("stall ts_valid", ts_valid, 1);
        check("stall ts_data", ts_data, expect_ts(1));
        check("stall ts_aborted", ts_aborted, 0);
        check("stall overrun", overrun, 1);
        check("stall frame_count", frame_count, 0);
        check("stall starts", start_cnt, 1);
        auto_ready = 1'b1;
        step();
        step();
        check("stall release frame_count", frame_count, 1);
        check("stall release ts_valid", ts_valid, 0);
        check("stall release log", log_data.size(), 1);
        next_second();
        check("stall next start", start_cnt, 2);
        check("stall next start sec", (start_sec_q.size() > 1) ? start_sec_q[1] : -1, 5);
        repeat (10) ms_step();
        check("stall second frame", frame_count, 2);

        // Extractor busy at the trigger; clear colliding with a later drop.
        do_reset();
        period_sec = 8'd1; window_ms = 10'd5; done_after = 3; cur_abort_ms = 5;
        ext_busy = 1'b1; enable = 1'b1;
        next_second();
        check("busy no start", start_cnt, 0);
        check("busy overrun", overrun, 1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        step();
        check("clear overrun", overrun, 0);
        clr_on_boundary = 1'b1;
        next_second();
        clr_on_boundary = 1'b0;
        check("set beats clear", overrun, 1);
        ext_busy = 1'b0;
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        next_second();
        repeat (10) ms_step();
        check("busy gone start", start_cnt, 1);
        check("busy gone frame_count", frame_count, 1);
        check("busy gone overrun", overrun, 0);

        // Asynchronous reset in the middle of a long capture.
        do_reset();
        period_sec = 8'd1; window_ms = 10'd5; done_after = 3; cur_abort_ms = 5;
        enable = 1'b1;
        next_second();
        repeat (10) ms_step();
        window_ms = 10'd1000; done_after = 0;
        next_second();
        next_second();
        ms_step();
        check("pre-reset frame_count", frame_count, 1);
        check("pre-reset overrun", overrun, 1);
        check("pre-reset starts", start_cnt, 2);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset ext_start", ext_start, 0);
        check("async reset ts_valid", ts_valid, 0);
        check("async reset frame_count", frame_count, 0);
        check("async reset overrun", overrun, 0);
        step();
        step();
        ext_running = 1'b0;
        period_sec = 8'd2; window_ms = 10'd5; done_after = 3;
        reset_n = 1'b1;
        next_second();
        check("post-reset first boundary", start_cnt, 2);
        next_second();
        check("post-reset start", start_cnt, 3);
        check("post-reset start sec", start_sec_q[start_sec_q.size() - 1], 5);
        repeat (10) ms_step();
        check("post-reset frame_count", frame_count, 1);
        check("reset no abort", abort_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_scheduler.md
Name: acq_scheduler

Overview:
Sequences spectrogram frame acquisitions against the free-running real-time-clock outputs. It detects RTC second boundaries and fires a capture every period_sec seconds. It starts the extractor, bounds each capture to window_ms milliseconds, and hands a 32-bit trigger timestamp to the readout logic over a valid/ready handshake. It sits between the RTC counter block and the spectrogram extractor datapath.

Parameters:
PERIOD_W, 8, width of period_sec (capture period in seconds)
WIN_W, 10, width of window_ms (capture timeout in milliseconds)
CNT_W, 16, width of frame_count

Ports:
clk  in  1  system clock; RTC fields are synchronous to it
reset_n  in  1  asynchronous, active-low reset
enable  in  1  level; scheduling active while high
period_sec  in  PERIOD_W  capture period in seconds; value 0 is treated as 1
window_ms  in  WIN_W  capture timeout in ms; value 0 is treated as 1
rtc_millisec  in  10  RTC milliseconds, 0..999
rtc_sec  in  6  RTC seconds
rtc_min  in  6  RTC minutes
rtc_hour  in  5  RTC hours
rtc_day  in  5  RTC day
ext_start  out  1  one-cycle capture start pulse to extractor
ext_busy  in  1  extractor busy
ext_done  in  1  one-cycle frame-complete pulse from extractor
ext_abort  out  1  one-cycle abort pulse on window timeout
ts_valid  out  1  timestamp available
ts_ready  in  1  consumer accepts timestamp
ts_data  out  32  {day[4:0], hour[4:0], min[5:0], sec[5:0], millisec[9:0]} at trigger
ts_aborted  out  1  qualifies ts_data; 1 = frame ended by timeout
frame_count  out  CNT_W  completed handshakes; wraps to 0
overrun  out  1  sticky: a trigger was dropped
clear_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0; prev_ms register 0.
- ms tick: rtc_millisec != prev_ms, where prev_ms is registered every cycle. Second boundary: ms tick with rtc_millisec == 0.
- Period counter: zeroed on entry to ARMED from IDLE, then counts second boundaries while enable is high, in every state except IDLE. Trigger: the boundary on which count+1 == max(period_sec,1). The counter then returns to 0, so the period stays fixed regardless of capture length.
- FSM states: IDLE, ARMED, START, RUN, REPORT.
- IDLE: go to ARMED when enable is high.
- ARMED: on trigger with ext_busy low, go to START. At that same edge, latch ts_data from the RTC inputs of the trigger cycle.
- ARMED: on trigger with ext_busy high, set overrun and stay in ARMED.
- ARMED: with enable low, go to IDLE.
- START: ext_start high for exactly this cycle, i.e. one cycle after the boundary is visible on the RTC inputs. Clear the window counter, then go to RUN.
- RUN: the window counter increments on each ms tick.
  - ext_done high: go to REPORT with ts_aborted=0.
  - Otherwise, when the counter reaches max(window_ms,1): ext_abort pulses for one cycle, then go to REPORT with ts_aborted=1.
  - ext_done and timeout in the same cycle: done wins, no abort.
- REPORT: ts_valid high; ts_data and ts_aborted held stable until ts_ready.
  - On the handshake cycle (ts_valid & ts_ready): increment frame_count, drop ts_valid next cycle, go to ARMED if enable is high, else IDLE.
- Triggers while in START, RUN or REPORT: dropped, overrun set.
- clear_overrun clears overrun. If a drop and a clear occur in the same cycle, set wins.
- enable low during START/RUN/REPORT: the frame completes normally (no forced abort), then the FSM goes to IDLE.
- period_sec and window_ms are sampled live; a change takes effect at the next comparison.
- Reset mid-capture: immediate return to reset values. No abort pulse is issued.

Decomposition:
- Shared package: FSM state enum; TS field offsets (MS_LSB=0, SEC_LSB=10, MIN_LSB=16, HOUR_LSB=22, DAY_LSB=27); constant MS_PER_SEC=1000.
- One sub-module, rtc_tick_detect: registers prev_ms and outputs ms_tick and sec_tick.

Test Plan:
- period_sec=2, window_ms=5, enable=1, extractor returns ext_done 3 ms after start: ext_start at seconds 2, 4, 6 boundaries; ts_data millisec=0 with sec=2,4,6; ts_aborted=0; frame_count=3.
- window_ms=4, extractor never asserts done: ext_abort one cycle on the 4th ms tick after start; ts_aborted=1; next trigger still on schedule.
- ts_ready held low for 3 s with period_sec=1: ts_valid held with ts_data unchanged; overrun=1; after ready, frame_count=1 and the next capture occurs at the next boundary.
- ext_busy high at a trigger: no ext_start; overrun=1. clear_overrun asserted in the same cycle as a later drop: overrun stays 1.
- ext_done coincident with window expiry: no ext_abort; ts_aborted=0.
- reset_n low during RUN: ext_start, ts_valid, frame_count and overrun all 0 asynchronously. After release with enable=1, the first capture comes period_sec boundaries later.
